// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1, LSB first.
//
// The receiver oversamples a single serial pin. It rebuilds each byte and
// presents it on a valid/ready holding register. Framing errors and
// overruns are flagged with one-cycle pulses.
//
// Build option:
//   UART_RX_PARITY_EN - when defined, an even-parity bit is expected
//                       between data bit 7 and the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4), default 52
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   rx           in   serial line, idle high, asynchronous to clock
//   data         out  received byte, stable while valid is high
//   valid        out  holding register full
//   ready        in   consumer accepts data when valid & ready
//   framing_err  out  one-cycle pulse: stop bit sampled low
//   parity_err   out  one-cycle pulse: parity mismatch (0 without parity)
//   overrun      out  one-cycle pulse: completed byte dropped
//   busy         out  high whenever the FSM is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 52
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          parOk;

  logic          sync1_q, rxS_q, rxPrev_q;

`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  // Reset to the idle-line level so that reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      rxS_q    <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= rx;
      rxS_q    <= sync1_q;
      rxPrev_q <= rxS_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    // A handshake empties the holding register unless a new byte lands on
    // the same edge (handled in STOP below).
    valid_d = valid_q & ~ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    parOk   = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Only a fresh 1->0 transition starts a frame; a line stuck low does not.
        if (rxPrev_q && !rxS_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_MID) begin
          if (!rxS_q) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Right shift: the first bit received settles into bit 0.
          shift_d = {rxS_q, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          par_d   = rxS_q;
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
          // Even parity: data bits plus parity bit hold an even count of ones.
          parOk  = (par_q == ^shift_q);
          perr_d = ~parOk;
`endif
          ferr_d = ~rxS_q;
          if (rxS_q && parOk) begin
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first, matching the frame format and bit period of the design's existing UART transmitter. It samples a single `rx` pin, reconstructs bytes and presents each one on a valid/ready holding register. Framing errors and overruns are flagged. It sits beside the IO block and feeds received bytes to the register/control logic.

## Interface
- `CLKS_PER_BIT`, default 52: clock cycles per serial bit. Must be ≥ 4. `HALF = CLKS_PER_BIT/2`, truncated.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; takes effect on the next rising edge of `clock`.
- `rx`  in  1: serial line, idle high, asynchronous to `clock`.
- `data`  out  8: received byte, stable while `valid` is high.
- `valid`  out  1: holding register full.
- `ready`  in  1: consumer accepts `data` in any cycle where `valid & ready` is high.
- `framing_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1: one-cycle pulse on parity mismatch; tied 0 without `UART_RX_PARITY_EN`.
- `overrun`  out  1: one-cycle pulse when a completed byte is dropped.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Input conditioning:
  - `rx` passes through a 2-flop synchronizer to produce `rx_s`.
  - `rx_prev` is `rx_s` delayed one cycle.
  - On reset, both `rx_s` and `rx_prev` are 1.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP. Bit counter `cnt` is sized to hold `CLKS_PER_BIT-1`; bit index is 3 bits.
- IDLE: when `rx_prev==1 && rx_s==0` (falling edge), go to START and set `cnt<=0`. A line held low with no new falling edge never starts a frame.
- START: increment `cnt`. When `cnt==HALF-1`, sample `rx_s`:
  - If 0: go to DATA, `cnt<=0`, `idx<=0`.
  - If 1: glitch; return to IDLE with no flags raised.
- DATA: increment `cnt`. When `cnt==CLKS_PER_BIT-1`:
  - Shift `rx_s` in at bit 7 (right shift, so the first bit received ends up as the LSB).
  - Set `cnt<=0` and increment `idx`.
  - After `idx==7`, go to PARITY if enabled, else STOP.
- STOP: when `cnt==CLKS_PER_BIT-1`, sample `rx_s` and return to IDLE.
  - Sample 1 with no parity error: deliver the byte.
  - Sample 0: pulse `framing_err`; discard the byte.
- Delivery, evaluated on the same edge as the stop sample:
  - If `valid==0`, or `valid==1 && ready==1`: load `data`, and `valid` is 1 next cycle.
  - If `valid==1 && ready==0`: pulse `overrun`; `data` keeps the old byte.
- A handshake (`valid & ready`) with no delivery on that edge clears `valid` next cycle.
- Reset at any point: state returns to IDLE. All outputs go to 0: `data=8'h00`, `valid=0`, `framing_err=0`, `parity_err=0`, `overrun=0`, `busy=0`.
- A partially received frame is discarded. The next frame starts on a fresh falling edge of `rx_s`.

## Timing
- E denotes the edge at which IDLE detects the falling edge of `rx_s`. The pin-to-`rx_s` delay is 2 cycles.
- Start bit is validated at E+HALF.
- Data bit k (k = 0..7) is sampled at E+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit is sampled at E+HALF+9·CLKS_PER_BIT; with parity enabled, at E+HALF+10·CLKS_PER_BIT.
- `valid`, `data` and the error pulses are visible in the cycle after the stop-sample edge. With the default 8N1 setting this is E+494, first high in cycle E+495.
- `busy` is high from E+1 through the stop-sample edge inclusive.
- Back-to-back frames are supported: a falling edge one cycle after the return to IDLE is accepted.
- Error and overrun pulses are exactly one cycle wide.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One even-parity bit follows bit 7. It is sampled one bit period after bit 7, then the FSM goes to STOP.
  - On mismatch, `parity_err` pulses on the stop-sample edge and the byte is discarded. `framing_err` is still evaluated independently.
- `UART_RX_PARITY_EN` undefined:
  - The PARITY state and its logic are absent.
  - `parity_err` is a constant 0 and the frame is 10 bits.

## Test plan
- Reset, then idle `rx=1` for 200 cycles: all outputs are 0 and `busy=0` throughout.
- 8N1 frame 0xA5 at 52 clocks/bit with `ready=0`: `data=8'hA5`, `valid` first high at E+495, `valid` held until `ready` is pulsed, then 0 the next cycle.
- `rx` low for 10 cycles, then high: no `valid`, no error flags, `busy` returns to 0 after E+26.
- Frame 0x3C with the stop bit driven 0: `framing_err` pulses once, `valid` stays 0, and a following good frame 0x11 is received correctly.
- Two frames (0x01 then 0x02) with `ready=0`: `overrun` pulses at the second stop sample and `data` stays 0x01. Repeat with `ready=1` on the second stop-sample edge: `data=0x02` and `valid` stays 1.
- Assert `reset` for one cycle midway through DATA: all outputs go to 0 and state to IDLE; a subsequent frame 0x5A is received intact. With `UART_RX_PARITY_EN`, 0x5A sent with parity bit 1: `parity_err` pulses and no `valid`.
